wb_regfile: RTL and testbench
=============================

# wb_regfile

Writeback-side architectural state for the five-stage MIPS core: the 32×32 general-purpose register file plus the HI/LO special registers. It consumes the writeback bundle that leaves the MEM/WB stage (GPR write and HI/LO write) and serves the decode stage's two GPR read ports and the execute stage's HI/LO read. Same-cycle writeback-to-read bypass is built in, so a value being written back is visible to readers in that same cycle.

## Interface
Parameters:
- REG_NUM, 32, number of GPRs; address width is log2(REG_NUM) = 5.
- DATA_W, 32, GPR and HI/LO data width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- wb_wd  in  5  GPR write address.
- wb_wreg  in  1  GPR write enable.
- wb_wdata  in  32  GPR write data.
- wb_whilo  in  1  HI/LO write enable.
- wb_hi  in  32  data for HI.
- wb_lo  in  32  data for LO.
- re1  in  1  read enable, port 1.
- raddr1  in  5  read address, port 1.
- rdata1  out  32  read data, port 1.
- re2  in  1  read enable, port 2.
- raddr2  in  5  read address, port 2.
- rdata2  out  32  read data, port 2.
- hi_o  out  32  current HI, with bypass.
- lo_o  out  32  current LO, with bypass.

## Operation
- **Reset.** On a rising edge with rst = 0:
  - All 32 GPRs, HI and LO are cleared to 0x00000000.
  - Any writeback presented in that cycle is discarded.
- **GPR write.** On a rising edge with rst = 1, wb_wreg = 1 and wb_wd ≠ 0: regs[wb_wd] ← wb_wdata.
  - Writes to $0 are dropped; $0 always reads 0.
- **HI/LO write.** On a rising edge with rst = 1 and wb_whilo = 1: HI ← wb_hi and LO ← wb_lo, updated together.
  - There is no partial HI-only or LO-only write.
- **GPR reads.** Each port is combinational. Priority, evaluated per port:
  1. rst = 0 → 0.
  2. raddr = 0 → 0.
  3. re = 1 and wb_wreg = 1 and wb_wd = raddr → wb_wdata (bypass).
  4. re = 1 → regs[raddr].
  5. Otherwise → 0.
- **HI/LO reads.** Combinational:
  - rst = 0 → 0.
  - wb_whilo = 1 → wb_hi / wb_lo (bypass).
  - Otherwise → stored HI / LO.
- **Both ports, same address.** Both ports may read the same address; both return identical data, including the bypassed value.
- **No hazards.** GPR writes and HI/LO writes are independent and may occur in the same cycle.

## Timing
- Write latency: the value is stored at the edge where it is presented.
  - It is visible through bypass in the presenting cycle.
  - It is visible from storage from the next cycle on.
- Read latency: 0 cycles (combinational from address/enable to data).
- Output reset values: rdata1, rdata2, hi_o and lo_o are all 0 while rst = 0.
  - After rst returns to 1, every GPR, HI and LO reads 0 until written.
- Reset asserted mid-stream: the reset edge wins over any simultaneous write. The next write accepted is the first edge with rst = 1.
- Back-to-back writes to the same GPR: the last edge wins. A reader in the cycle of the second write sees the second value via bypass.
- Write with wb_wreg = 1, wb_wd = 0: no state change and no bypass; a read of $0 returns 0.

## Structure
- Shared package constants: ZeroWord, NOPRegAddr (5'b0), WriteEnable/WriteDisable, ReadEnable/ReadDisable, RegAddrBus width, RegBus width, RegNum.
- The active-low reset level is defined once in the package as RstEnable = 1'b0 for this block's domain.
- Sub-module: hilo_reg, holding the HI/LO storage, the combined write and the bypass mux. wb_regfile instantiates hilo_reg alongside the GPR array.

## Test plan
- **Reset clears state.** Write regs[5] = 0x12345678, then hold rst = 0 for one edge, then read raddr1 = 5 → 0x00000000. hi_o and lo_o → 0.
- **Write then read.** Write wb_wd = 3, wb_wdata = 0xDEADBEEF. Same cycle, re1 = 1, raddr1 = 3 → rdata1 = 0xDEADBEEF (bypass). Next cycle with wb_wreg = 0 → still 0xDEADBEEF (stored).
- **$0 hardwired.** wb_wreg = 1, wb_wd = 0, wb_wdata = 0xFFFFFFFF. Read raddr2 = 0 in the same cycle and the next → 0 both times.
- **Read enable gating.** regs[7] = 0xA5A5A5A5, re1 = 0, raddr1 = 7 → rdata1 = 0. Port 2 with re2 = 1, raddr2 = 7 → 0xA5A5A5A5.
- **HI/LO.** wb_whilo = 1, wb_hi = 0x1, wb_lo = 0x2 → hi_o = 0x1 and lo_o = 0x2 in the same cycle. Next cycle with wb_whilo = 0 → unchanged. Then write wb_hi = 0x3, wb_lo = 0x4 while simultaneously writing GPR 9 = 0x55 → both updates take effect.
- **Reset beats write.** rst = 0 with wb_wreg = 1, wb_wd = 4, wb_wdata = 0x77 at the same edge. Then rst = 1 and read regs[4] → 0.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared constants for the writeback register file: bus widths, enable levels
// and the reset level for this clock domain.
package wb_regfile_pkg;
  localparam int RegNum      = 32;
  localparam int RegAddrBusW = 5;
  localparam int RegBusW     = 32;

  localparam logic [RegBusW-1:0]     ZeroWord     = '0;
  localparam logic [RegAddrBusW-1:0] NOPRegAddr   = 5'b0;
  localparam logic                   WriteEnable  = 1'b1;
  localparam logic                   WriteDisable = 1'b0;
  localparam logic                   ReadEnable   = 1'b1;
  localparam logic                   ReadDisable  = 1'b0;
  localparam logic                   RstEnable    = 1'b0;
endpackage

// File: rtl/wb_regfile_hilo_reg.sv
// HI/LO special registers: combined write from writeback plus same-cycle bypass.
module hilo_reg
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = RegBusW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              whilo,
  input  logic [DATA_W-1:0] wb_hi,
  input  logic [DATA_W-1:0] wb_lo,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  logic [DATA_W-1:0] hi_q, lo_q;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      hi_q <= DATA_W'(ZeroWord);
      lo_q <= DATA_W'(ZeroWord);
    end else if (whilo == WriteEnable) begin
      hi_q <= wb_hi;
      lo_q <= wb_lo;
    end
  end

  always_comb begin
    hi = hi_q;
    lo = lo_q;
    if (rst == RstEnable) begin
      hi = DATA_W'(ZeroWord);
      lo = DATA_W'(ZeroWord);
    end else if (whilo == WriteEnable) begin
      hi = wb_hi;
      lo = wb_lo;
    end
  end
endmodule

// File: rtl/wb_regfile.sv
// Architectural GPR file and HI/LO for the MIPS core, with writeback-to-read
// bypass on both decode read ports and on the HI/LO read.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int REG_NUM = RegNum,
  parameter int DATA_W  = RegBusW,
  localparam int AW     = $clog2(REG_NUM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     wb_wd,
  input  logic              wb_wreg,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              wb_whilo,
  input  logic [DATA_W-1:0] wb_hi,
  input  logic [DATA_W-1:0] wb_lo,
  input  logic              re1,
  input  logic [AW-1:0]     raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [AW-1:0]     raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);
  localparam int PORTS = 2;

  logic [DATA_W-1:0] regs [REG_NUM];
  logic                         gpr_we;
  logic [PORTS-1:0]             re;
  logic [PORTS-1:0][AW-1:0]     raddr;
  logic [PORTS-1:0][DATA_W-1:0] rdata;

  // $0 is never written, so it stays at its reset value of zero.
  assign gpr_we = (wb_wreg == WriteEnable) && (wb_wd != AW'(NOPRegAddr));

  always_ff @(posedge clk) begin
    if (rst == RstEnable) regs <= '{default: '0};
    else if (gpr_we)      regs[wb_wd] <= wb_wdata;
  end

  assign re    = {re2, re1};
  assign raddr = {raddr2, raddr1};

  for (genvar p = 0; p < PORTS; p++) begin : g_rd
    always_comb begin
      rdata[p] = DATA_W'(ZeroWord);
      if (rst == RstEnable || raddr[p] == AW'(NOPRegAddr))
        rdata[p] = DATA_W'(ZeroWord);
      else if (re[p] == ReadEnable && wb_wreg == WriteEnable && wb_wd == raddr[p])
        rdata[p] = wb_wdata;
      else if (re[p] == ReadEnable)
        rdata[p] = regs[raddr[p]];
    end
  end

  assign rdata1 = rdata[0];
  assign rdata2 = rdata[1];

  hilo_reg #(.DATA_W(DATA_W)) u_hilo (
    .clk   (clk),
    .rst   (rst),
    .whilo (wb_whilo),
    .wb_hi (wb_hi),
    .wb_lo (wb_lo),
    .hi    (hi_o),
    .lo    (lo_o)
  );
endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed scenarios then random traffic, expected read
// data queued per driven cycle and compared when the outputs settle.
module tb_wb_regfile;
  logic        clk;
  logic        rst;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        wb_whilo;
  logic [31:0] wb_hi, wb_lo;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2, hi_o, lo_o;

  wb_regfile dut (
    .clk(clk), .rst(rst), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] r1, r2, hi, lo;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_hi, m_lo;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_rd(input logic r, input logic e, input logic [4:0] a);
    if (!r || a == 5'd0)                   return 32'h0;
    if (e && wb_wreg && wb_wd == a)        return wb_wdata;
    if (e)                                 return m_regs[a];
    return 32'h0;
  endfunction

  // Called just after a falling edge; one full cycle per call.
  task automatic cyc(input string tag, input logic r,
                     input logic wreg, input logic [4:0] wd, input logic [31:0] wdata,
                     input logic whl, input logic [31:0] h, input logic [31:0] l,
                     input logic e1, input logic [4:0] a1,
                     input logic e2, input logic [4:0] a2);
    exp_t x;
    exp_t got_x;
    string t;
    rst = r; wb_wreg = wreg; wb_wd = wd; wb_wdata = wdata;
    wb_whilo = whl; wb_hi = h; wb_lo = l;
    re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
    x.r1 = m_rd(r, e1, a1);
    x.r2 = m_rd(r, e2, a2);
    x.hi = !r ? 32'h0 : (whl ? h : m_hi);
    x.lo = !r ? 32'h0 : (whl ? l : m_lo);
    sb_q.push_back(x);
    tag_q.push_back(tag);
    #1;
    got_x = '{r1: rdata1, r2: rdata2, hi: hi_o, lo: lo_o};
    x = sb_q.pop_front();
    t = tag_q.pop_front();
    chk({t, ".rdata1"}, got_x.r1, x.r1);
    chk({t, ".rdata2"}, got_x.r2, x.r2);
    chk({t, ".hi_o"},   got_x.hi, x.hi);
    chk({t, ".lo_o"},   got_x.lo, x.lo);
    @(posedge clk);
    if (!r) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_hi = 32'h0; m_lo = 32'h0;
    end else begin
      if (wreg && wd != 5'd0) m_regs[wd] = wdata;
      if (whl) begin m_hi = h; m_lo = l; end
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_hi = 32'h0; m_lo = 32'h0;
    rst = 1'b0; wb_wreg = 1'b0; wb_wd = '0; wb_wdata = '0;
    wb_whilo = 1'b0; wb_hi = '0; wb_lo = '0;
    re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
    @(negedge clk);

    cyc("rst0",     0, 0, 0, 0,            0, 0, 0, 1, 5, 1, 6);
    cyc("rst1",     0, 0, 0, 0,            0, 0, 0, 1, 5, 1, 6);
    // reset clears state
    cyc("wr5",      1, 1, 5, 32'h12345678, 1, 32'hAA, 32'hBB, 1, 5, 1, 5);
    cyc("rd5",      1, 0, 0, 0,            0, 0, 0, 1, 5, 0, 0);
    cyc("rstmid",   0, 0, 0, 0,            0, 0, 0, 1, 5, 1, 5);
    cyc("rd5clr",   1, 0, 0, 0,            0, 0, 0, 1, 5, 1, 5);
    // write then read: bypass, then storage
    cyc("wr3byp",   1, 1, 3, 32'hDEADBEEF, 0, 0, 0, 1, 3, 0, 0);
    cyc("rd3",      1, 0, 0, 0,            0, 0, 0, 1, 3, 1, 3);
    // $0 hardwired
    cyc("wr0",      1, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 1, 0);
    cyc("rd0",      1, 0, 0, 0,            0, 0, 0, 1, 0, 1, 0);
    // read enable gating
    cyc("wr7",      1, 1, 7, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 0, 0);
    cyc("gate7",    1, 0, 0, 0,            0, 0, 0, 0, 7, 1, 7);
    cyc("gatebyp",  1, 1, 7, 32'h0BADF00D, 0, 0, 0, 0, 7, 1, 7);
    // HI/LO
    cyc("hilo12",   1, 0, 0, 0,            1, 32'h1, 32'h2, 0, 0, 0, 0);
    cyc("hilohold", 1, 0, 0, 0,            0, 32'hF, 32'hF, 0, 0, 0, 0);
    cyc("hilo34g9", 1, 1, 9, 32'h55,       1, 32'h3, 32'h4, 1, 9, 1, 9);
    cyc("rd9",      1, 0, 0, 0,            0, 0, 0, 1, 9, 1, 9);
    // back-to-back writes, last wins
    cyc("b2b_a",    1, 1, 10, 32'h11,      0, 0, 0, 1, 10, 0, 0);
    cyc("b2b_b",    1, 1, 10, 32'h22,      0, 0, 0, 1, 10, 1, 10);
    cyc("b2b_rd",   1, 0, 0, 0,            0, 0, 0, 1, 10, 1, 10);
    // reset beats a simultaneous write
    cyc("rstwr4",   0, 1, 4, 32'h77,       1, 32'h9, 32'h9, 1, 4, 1, 4);
    cyc("rd4",      1, 0, 0, 0,            0, 0, 0, 1, 4, 1, 10);

    for (int n = 0; n < 400; n++) begin
      cyc("rand", ($urandom_range(39) != 0),
          1'($urandom), 5'($urandom), $urandom,
          ($urandom_range(3) == 0), $urandom, $urandom,
          ($urandom_range(3) != 0), 5'($urandom),
          ($urandom_range(3) != 0), 5'($urandom));
    end

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
